// File: rtl/hazard_fwd_unit.sv
// Forwarding-select and load-use stall control for the 5-stage MIPS pipeline.
// Optional stall statistics counter enabled by defining HAZARD_STALL_CNT_EN.
module hazard_fwd_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           EX_MEM_RegWrite,
    input  logic [REG_ADDR_W-1:0]          EX_MEM_RegisterRd,
    input  logic                           MEM_WB_RegWrite,
    input  logic [REG_ADDR_W-1:0]          MEM_WB_RegisterRd,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]  ID_EX_RegisterSrc,
    input  logic                           ID_EX_MemRead,
    input  logic [REG_ADDR_W-1:0]          ID_EX_RegisterRd,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]  IF_ID_RegisterSrc,
    input  logic [NUM_SRC-1:0]             IF_ID_SrcUsed,
    input  logic                           Flush,
    output logic [2*NUM_SRC-1:0]           Forward,
    output logic                           PCWrite,
    output logic                           IF_ID_Write,
    output logic                           ID_EX_Bubble,
    output logic [CNT_W-1:0]               StallCount
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } stallState_e;

    localparam logic [3:0] REM_INIT = 4'(LOAD_LAT - 1);

    stallState_e state;
    stallState_e stateNext;
    logic [3:0]  rem;
    logic [3:0]  remNext;
    logic        srcMatch;
    logic        loadUse;
    logic        stallCycle;

    // The younger result (EX/MEM) wins over MEM/WB; register zero never forwards.
    always_comb begin
        Forward = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (EX_MEM_RegWrite && (EX_MEM_RegisterRd != '0) &&
                (EX_MEM_RegisterRd == ID_EX_RegisterSrc[i*REG_ADDR_W +: REG_ADDR_W])) begin
                Forward[2*i +: 2] = 2'b10;
            end else if (MEM_WB_RegWrite && (MEM_WB_RegisterRd != '0) &&
                         (MEM_WB_RegisterRd == ID_EX_RegisterSrc[i*REG_ADDR_W +: REG_ADDR_W])) begin
                Forward[2*i +: 2] = 2'b01;
            end
        end
    end

    always_comb begin
        srcMatch = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (IF_ID_SrcUsed[i] &&
                (IF_ID_RegisterSrc[i*REG_ADDR_W +: REG_ADDR_W] == ID_EX_RegisterRd)) begin
                srcMatch = 1'b1;
            end
        end
    end

    assign loadUse = rst_n && ID_EX_MemRead && (ID_EX_RegisterRd != '0) && srcMatch;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
            rem   <= '0;
        end else begin
            state <= stateNext;
            rem   <= remNext;
        end
    end

    // rem counts the stall cycles still owed after the current one.
    always_comb begin
        stateNext = state;
        remNext   = rem;
        if (Flush) begin
            stateNext = RUN;
            remNext   = '0;
        end else begin
            case (state)
                RUN: begin
                    if (loadUse && (LOAD_LAT > 1)) begin
                        stateNext = STALL;
                        remNext   = REM_INIT;
                    end
                end
                STALL: begin
                    if (rem <= 4'd1) begin
                        stateNext = RUN;
                        remNext   = '0;
                    end else begin
                        remNext = rem - 4'd1;
                    end
                end
                default: begin
                    stateNext = RUN;
                    remNext   = '0;
                end
            endcase
        end
    end

    always_comb begin
        stallCycle = 1'b0;
        if (rst_n && !Flush) begin
            stallCycle = (state == STALL) || loadUse;
        end
        PCWrite      = !stallCycle;
        IF_ID_Write  = !stallCycle;
        ID_EX_Bubble = stallCycle;
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] stallCountQ;

    // Saturates at all-ones so long runs never wrap back to a small value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stallCountQ <= '0;
        end else if (stallCycle && (stallCountQ != '1)) begin
            stallCountQ <= stallCountQ + CNT_W'(1);
        end
    end

    assign StallCount = stallCountQ;
`else
    assign StallCount = '0;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: a LOAD_LAT=1 instance and a LOAD_LAT=3/CNT_W=4
// instance share stimulus; vector table, directed sequences and random cycles vs a reference model.
module tb_hazard_fwd_unit;

    localparam int AW = 5;

`ifdef HAZARD_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        logic          exW;
        logic [AW-1:0] exRd;
        logic          wbW;
        logic [AW-1:0] wbRd;
        logic [9:0]    idExSrc;
        logic          memRead;
        logic [AW-1:0] idExRd;
        logic [9:0]    ifIdSrc;
        logic [1:0]    used;
        logic          flush;
        logic [3:0]    expFwd;
        logic          expStall;
    } vec_t;

    logic          clk;
    logic          rstN;
    logic          exW;
    logic [AW-1:0] exRd;
    logic          wbW;
    logic [AW-1:0] wbRd;
    logic [9:0]    idExSrc;
    logic          memRead;
    logic [AW-1:0] idExRd;
    logic [9:0]    ifIdSrc;
    logic [1:0]    used;
    logic          flush;

    logic [3:0]  fwd1, fwd3;
    logic        pcw1, pcw3, ifw1, ifw3, bub1, bub3;
    logic [15:0] cnt1;
    logic [3:0]  cnt3;

    int checks = 0;
    int errors = 0;
    int left1 = 0, left3 = 0, count1 = 0, count3 = 0;

    hazard_fwd_unit dut1 (
        .clk(clk), .rst_n(rstN),
        .EX_MEM_RegWrite(exW), .EX_MEM_RegisterRd(exRd),
        .MEM_WB_RegWrite(wbW), .MEM_WB_RegisterRd(wbRd),
        .ID_EX_RegisterSrc(idExSrc), .ID_EX_MemRead(memRead), .ID_EX_RegisterRd(idExRd),
        .IF_ID_RegisterSrc(ifIdSrc), .IF_ID_SrcUsed(used), .Flush(flush),
        .Forward(fwd1), .PCWrite(pcw1), .IF_ID_Write(ifw1), .ID_EX_Bubble(bub1),
        .StallCount(cnt1)
    );

    hazard_fwd_unit #(.LOAD_LAT(3), .CNT_W(4)) dut3 (
        .clk(clk), .rst_n(rstN),
        .EX_MEM_RegWrite(exW), .EX_MEM_RegisterRd(exRd),
        .MEM_WB_RegWrite(wbW), .MEM_WB_RegisterRd(wbRd),
        .ID_EX_RegisterSrc(idExSrc), .ID_EX_MemRead(memRead), .ID_EX_RegisterRd(idExRd),
        .IF_ID_RegisterSrc(ifIdSrc), .IF_ID_SrcUsed(used), .Flush(flush),
        .Forward(fwd3), .PCWrite(pcw3), .IF_ID_Write(ifw3), .ID_EX_Bubble(bub3),
        .StallCount(cnt3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] fwdRef();
        logic [3:0] r = '0;
        for (int i = 0; i < 2; i++) begin
            int src = int'(idExSrc[i*AW +: AW]);
            if (exW && exRd != 0 && int'(exRd) == src)      r[2*i +: 2] = 2'b10;
            else if (wbW && wbRd != 0 && int'(wbRd) == src) r[2*i +: 2] = 2'b01;
        end
        return r;
    endfunction

    function automatic bit detectRef();
        bit hit = 1'b0;
        for (int i = 0; i < 2; i++)
            if (used[i] && ifIdSrc[i*AW +: AW] == idExRd) hit = 1'b1;
        return rstN && memRead && idExRd != 0 && hit;
    endfunction

    // left = stall cycles still owed after the previous decision.
    function automatic bit stallRef(input int left);
        if (!rstN || flush) return 1'b0;
        if (left > 0) return 1'b1;
        return detectRef();
    endfunction

    function automatic int nextLeft(input int left, input int lat);
        if (!rstN || flush) return 0;
        if (left > 0) return left - 1;
        if (detectRef()) return lat - 1;
        return 0;
    endfunction

    task automatic applyStimulus(input vec_t v);
        exW = v.exW; exRd = v.exRd; wbW = v.wbW; wbRd = v.wbRd;
        idExSrc = v.idExSrc; memRead = v.memRead; idExRd = v.idExRd;
        ifIdSrc = v.ifIdSrc; used = v.used; flush = v.flush;
    endtask

    task automatic setIdle();
        exW = 0; exRd = 0; wbW = 0; wbRd = 0; idExSrc = 0;
        memRead = 0; idExRd = 0; ifIdSrc = 0; used = 0; flush = 0;
    endtask

    task automatic setLoadUse();
        setIdle();
        memRead = 1'b1; idExRd = 5'd5; ifIdSrc = {5'd5, 5'd2}; used = 2'b10;
    endtask

    task automatic checkOutput();
        bit s1 = stallRef(left1);
        bit s3 = stallRef(left3);
        checkVal("fwd1", 32'(fwd1), 32'(fwdRef()));
        checkVal("fwd3", 32'(fwd3), 32'(fwdRef()));
        checkVal("pcw1", 32'(pcw1), 32'(!s1));
        checkVal("ifw1", 32'(ifw1), 32'(!s1));
        checkVal("bub1", 32'(bub1), 32'(s1));
        checkVal("pcw3", 32'(pcw3), 32'(!s3));
        checkVal("ifw3", 32'(ifw3), 32'(!s3));
        checkVal("bub3", 32'(bub3), 32'(s3));
        checkVal("cnt1", 32'(cnt1), CNT_EN ? 32'(count1) : 32'd0);
        checkVal("cnt3", 32'(cnt3), CNT_EN ? 32'(count3) : 32'd0);
    endtask

    task automatic advance();
        bit s1 = stallRef(left1);
        bit s3 = stallRef(left3);
        int n1 = nextLeft(left1, 1);
        int n3 = nextLeft(left3, 3);
        if (!rstN) begin
            count1 = 0; count3 = 0;
        end else begin
            if (s1 && count1 < 65535) count1++;
            if (s3 && count3 < 15) count3++;
        end
        @(posedge clk);
        #1;
        left1 = n1; left3 = n3;
    endtask

    task automatic tick();
        #1;
        checkOutput();
        advance();
    endtask

    task automatic doReset();
        setIdle();
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{1'b1, 5'd3, 1'b1, 5'd3,  {5'd3, 5'd3},   1'b0, 5'd0, 10'd0, 2'b00, 1'b0, 4'b1010, 1'b0};
        vecs[1]  = '{1'b0, 5'd3, 1'b1, 5'd3,  {5'd3, 5'd3},   1'b0, 5'd0, 10'd0, 2'b00, 1'b0, 4'b0101, 1'b0};
        vecs[2]  = '{1'b1, 5'd0, 1'b1, 5'd0,  {5'd0, 5'd0},   1'b0, 5'd0, 10'd0, 2'b00, 1'b0, 4'b0000, 1'b0};
        vecs[3]  = '{1'b1, 5'd3, 1'b1, 5'd7,  {5'd7, 5'd3},   1'b0, 5'd0, 10'd0, 2'b00, 1'b0, 4'b0110, 1'b0};
        vecs[4]  = '{1'b1, 5'd4, 1'b0, 5'd7,  {5'd7, 5'd4},   1'b0, 5'd0, 10'd0, 2'b00, 1'b0, 4'b0010, 1'b0};
        vecs[5]  = '{1'b1, 5'd9, 1'b1, 5'd12, {5'd9, 5'd12},  1'b0, 5'd0, 10'd0, 2'b00, 1'b0, 4'b1001, 1'b0};
        vecs[6]  = '{1'b0, 5'd0, 1'b0, 5'd0,  10'd0, 1'b1, 5'd0, {5'd0, 5'd0}, 2'b11, 1'b0, 4'b0000, 1'b0};
        vecs[7]  = '{1'b0, 5'd0, 1'b0, 5'd0,  10'd0, 1'b1, 5'd5, {5'd5, 5'd2}, 2'b10, 1'b0, 4'b0000, 1'b1};
        vecs[8]  = '{1'b0, 5'd0, 1'b0, 5'd0,  10'd0, 1'b1, 5'd5, {5'd5, 5'd2}, 2'b00, 1'b0, 4'b0000, 1'b0};
        vecs[9]  = '{1'b0, 5'd0, 1'b0, 5'd0,  10'd0, 1'b1, 5'd5, {5'd2, 5'd5}, 2'b01, 1'b0, 4'b0000, 1'b1};
        vecs[10] = '{1'b0, 5'd0, 1'b0, 5'd0,  10'd0, 1'b1, 5'd5, {5'd5, 5'd5}, 2'b11, 1'b1, 4'b0000, 1'b0};
        vecs[11] = '{1'b0, 5'd0, 1'b0, 5'd0,  10'd0, 1'b0, 5'd5, {5'd5, 5'd5}, 2'b11, 1'b0, 4'b0000, 1'b0};

        setIdle();
        rstN = 1'b0;
        @(posedge clk);
        #1;
        rstN = 1'b1;
        #1;
        checkVal("rstPcw", 32'(pcw1), 32'd1);
        checkVal("rstBub", 32'(bub3), 32'd0);
        checkVal("rstCnt", 32'(cnt1), 32'd0);
        checkOutput();
        advance();

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkVal($sformatf("tblFwd%0d", i), 32'(fwd1), 32'(vecs[i].expFwd));
            checkVal($sformatf("tblBub%0d", i), 32'(bub1), 32'(vecs[i].expStall));
            checkVal($sformatf("tblPcw%0d", i), 32'(pcw1), 32'(!vecs[i].expStall));
            checkOutput();
            advance();
        end

        // Three-cycle stall on the LOAD_LAT=3 instance, one on the default instance.
        doReset();
        setLoadUse();
        #1;
        checkVal("lat3Bub0", 32'(bub3), 32'd1);
        checkVal("lat1Bub0", 32'(bub1), 32'd1);
        checkOutput();
        advance();
        setIdle();
        for (int k = 0; k < 4; k++) begin
            #1;
            checkVal($sformatf("lat3Bub%0d", k + 1), 32'(bub3), (k < 2) ? 32'd1 : 32'd0);
            checkVal($sformatf("lat1Bub%0d", k + 1), 32'(bub1), 32'd0);
            checkOutput();
            advance();
        end
        checkVal("lat3Cnt", 32'(cnt3), CNT_EN ? 32'd3 : 32'd0);
        checkVal("lat1Cnt", 32'(cnt1), CNT_EN ? 32'd1 : 32'd0);

        // Flush during the second stall cycle.
        doReset();
        setLoadUse();
        tick();
        setIdle();
        flush = 1'b1;
        #1;
        checkVal("flushBub", 32'(bub3), 32'd0);
        checkVal("flushPcw", 32'(pcw3), 32'd1);
        checkOutput();
        advance();
        flush = 1'b0;
        #1;
        checkVal("flushRun", 32'(bub3), 32'd0);
        checkVal("flushCnt", 32'(cnt3), CNT_EN ? 32'd1 : 32'd0);
        checkOutput();
        advance();

        setLoadUse();
        flush = 1'b1;
        #1;
        checkVal("coFlush1", 32'(bub1), 32'd0);
        checkVal("coFlush3", 32'(bub3), 32'd0);
        checkOutput();
        advance();
        setIdle();
        tick();

        // Reset asserted in the middle of a stall.
        doReset();
        setLoadUse();
        tick();
        setIdle();
        rstN = 1'b0;
        #1;
        checkVal("rstMidPcw", 32'(pcw3), 32'd1);
        checkVal("rstMidBub", 32'(bub3), 32'd0);
        checkOutput();
        advance();
        rstN = 1'b1;
        #1;
        checkVal("rstMidRun", 32'(bub3), 32'd0);
        checkVal("rstMidCnt", 32'(cnt3), 32'd0);
        checkOutput();
        advance();
        tick();

        // 21 stall cycles on the 4-bit counter instance.
        doReset();
        for (int k = 0; k < 7; k++) begin
            setLoadUse();
            tick();
            setIdle();
            tick();
            tick();
        end
        #1;
        checkVal("satCnt3", 32'(cnt3), CNT_EN ? 32'd15 : 32'd0);
        checkVal("satCnt1", 32'(cnt1), CNT_EN ? 32'd7 : 32'd0);

        for (int n = 0; n < 400; n++) begin
            rstN    = ($urandom_range(0, 39) != 0);
            exW     = 1'($urandom_range(0, 1));
            exRd    = 5'($urandom_range(0, 3));
            wbW     = 1'($urandom_range(0, 1));
            wbRd    = 5'($urandom_range(0, 3));
            idExSrc = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            memRead = ($urandom_range(0, 2) != 0);
            idExRd  = 5'($urandom_range(0, 3));
            ifIdSrc = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            used    = 2'($urandom_range(0, 3));
            flush   = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
